// File: rtl/paddle_motion_ctrl.sv
// ---------------------------------------------------------------------------
// paddle_motion_ctrl
//   Per-frame motion sequencer for the left paddle. Arbitrates Y-motion
//   between keyboard (MANUAL) and a ball-tracking autopilot (AUTO), handles
//   pause (run low) and recenter requests, and clamps the paddle centre to
//   the legal play-field range. Everything advances only on frame_tick; the
//   results appear on the following cycle together with a one-cycle update.
//
//   Optional feature macro: PADDLE_CTRL_ACCEL_EN
//     Defined   : MANUAL keeps a saturating 4-bit hold counter of consecutive
//                 frames with the same key; the step doubles once hold >= 8.
//     Undefined : manual step is always STEP; no hold counter exists.
//
// Ports
//   vga_clk       in   clock
//   Reset_n       in   asynchronous active-low reset
//   frame_tick    in   one-cycle pulse per frame
//   run           in   game running; low pauses the paddle (IDLE)
//   recenter      in   one-cycle request to return the paddle to Y_CENTER
//   key_up        in   level, move up (decreasing Y)
//   key_down      in   level, move down (increasing Y)
//   ball_y[9:0]   in   ball centre Y
//   ball_valid    in   ball_y meaningful
//   paddle_y[9:0] out  paddle centre Y
//   paddle_motion out  two's-complement delta applied at the last update
//   paddle_size   out  constant P_SIZE (half-height)
//   mode[1:0]     out  0 IDLE, 1 MANUAL, 2 AUTO, 3 RECENTER
//   update        out  one-cycle pulse when paddle_y/paddle_motion are written
// ---------------------------------------------------------------------------
module paddle_motion_ctrl #(
    parameter int unsigned Y_CENTER    = 240,
    parameter int unsigned Y_MIN       = 0,
    parameter int unsigned Y_MAX       = 479,
    parameter int unsigned P_SIZE      = 80,
    parameter int unsigned STEP        = 2,
    parameter int unsigned AUTO_STEP   = 1,
    parameter int unsigned IDLE_FRAMES = 120,
    parameter int unsigned DEADBAND    = 4
) (
    input  logic       vga_clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic       run,
    input  logic       recenter,
    input  logic       key_up,
    input  logic       key_down,
    input  logic [9:0] ball_y,
    input  logic       ball_valid,
    output logic [9:0] paddle_y,
    output logic [9:0] paddle_motion,
    output logic [9:0] paddle_size,
    output logic [1:0] mode,
    output logic       update
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MANUAL   = 2'd1,
        ST_AUTO     = 2'd2,
        ST_RECENTER = 2'd3
    } state_t;

    localparam int unsigned IW = $clog2(IDLE_FRAMES + 1);

    localparam logic signed [10:0] C_LO     = 11'(Y_MIN + P_SIZE);
    localparam logic signed [10:0] C_HI     = 11'(Y_MAX - P_SIZE);
    localparam logic signed [10:0] C_CENTER = 11'(Y_CENTER);
    localparam logic signed [10:0] C_STEP   = 11'(STEP);
    localparam logic signed [10:0] C_ASTEP  = 11'(AUTO_STEP);
    localparam logic        [10:0] C_STEP_U = 11'(STEP);
    localparam logic        [10:0] C_DBAND  = 11'(DEADBAND);

    function automatic logic [10:0] f_abs(input logic signed [10:0] v);
        return v[10] ? $unsigned(-v) : $unsigned(v);
    endfunction

    state_t          r_state;
    logic [9:0]      r_paddle_y;
    logic [9:0]      r_motion;
    logic            r_update;
    logic [IW-1:0]   r_idle_cnt;
    logic            r_pending;

    logic                w_key;
    logic                w_pend;
    logic signed [10:0]  w_y;
    logic signed [10:0]  w_ball_diff;
    logic signed [10:0]  w_ctr_diff;
    logic signed [10:0]  w_man_mag;
    logic signed [10:0]  w_man_delta;
    logic signed [10:0]  w_delta;
    logic signed [10:0]  w_sum;
    logic signed [10:0]  w_clamped;
    logic signed [10:0]  w_applied;
    logic [IW-1:0]       w_idle_inc;
    logic [IW-1:0]       w_idle_next;
    logic                w_pend_next;
    logic                w_snap;
    state_t              w_next_state;

    assign w_key       = key_up ^ key_down;
    // A request arriving while already recentering is dropped.
    assign w_pend      = r_pending | (recenter & (r_state != ST_RECENTER));
    assign w_y         = $signed({1'b0, r_paddle_y});
    assign w_ball_diff = $signed({1'b0, ball_y}) - w_y;
    assign w_ctr_diff  = C_CENTER - w_y;
    assign w_idle_inc  = r_idle_cnt + IW'(1);

`ifdef PADDLE_CTRL_ACCEL_EN
    logic       [3:0] r_hold;
    logic             r_last_up;
    logic             w_same;
    logic       [3:0] w_hold_next;

    // Hold only continues while still in MANUAL with the same key as last frame.
    assign w_same      = (r_state == ST_MANUAL) && (r_hold != 4'd0) && (r_last_up == key_up);
    assign w_man_mag   = (w_same && (r_hold >= 4'd8)) ? (C_STEP + C_STEP) : C_STEP;
    assign w_hold_next = ((w_next_state == ST_MANUAL) && w_key) ?
                         (w_same ? ((r_hold == 4'd15) ? 4'd15 : r_hold + 4'd1) : 4'd1) :
                         4'd0;

    always_ff @(posedge vga_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_hold    <= '0;
            r_last_up <= 1'b0;
        end else if (frame_tick) begin
            r_hold <= w_hold_next;
            if (w_key) begin
                r_last_up <= key_up;
            end
        end
    end
`else
    assign w_man_mag = C_STEP;
`endif

    assign w_man_delta = key_up ? -w_man_mag : w_man_mag;

    always_comb begin
        w_next_state = r_state;
        w_delta      = '0;
        w_snap       = 1'b0;
        w_idle_next  = '0;
        w_pend_next  = w_pend;
        w_sum        = '0;
        w_clamped    = '0;
        w_applied    = '0;

        if (!run) begin
            w_next_state = ST_IDLE;
        end else if (w_pend || (r_state == ST_RECENTER)) begin
            // Recenter step applies on the same frame the request is consumed.
            w_pend_next = 1'b0;
            if (f_abs(w_ctr_diff) <= C_STEP_U) begin
                w_snap       = 1'b1;
                w_next_state = ST_AUTO;
            end else begin
                w_next_state = ST_RECENTER;
                w_delta      = w_ctr_diff[10] ? -C_STEP : C_STEP;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_key) begin
                        w_next_state = ST_MANUAL;
                        w_delta      = w_man_delta;
                    end else begin
                        w_next_state = ST_AUTO;
                    end
                end
                ST_MANUAL: begin
                    if (w_key) begin
                        w_delta = w_man_delta;
                    end else if (w_idle_inc == IW'(IDLE_FRAMES)) begin
                        w_next_state = ST_AUTO;
                    end else begin
                        w_idle_next = w_idle_inc;
                    end
                end
                ST_AUTO: begin
                    if (w_key) begin
                        w_next_state = ST_MANUAL;
                        w_delta      = w_man_delta;
                    end else if (ball_valid && (f_abs(w_ball_diff) > C_DBAND)) begin
                        w_delta = w_ball_diff[10] ? -C_ASTEP : C_ASTEP;
                    end
                end
                default: begin
                    w_next_state = r_state;
                end
            endcase
        end

        w_sum = w_snap ? C_CENTER : (w_y + w_delta);
        if (w_sum < C_LO) begin
            w_clamped = C_LO;
        end else if (w_sum > C_HI) begin
            w_clamped = C_HI;
        end else begin
            w_clamped = w_sum;
        end
        // Report what actually moved, so a pinned paddle shows zero motion.
        w_applied = w_clamped - w_y;
    end

    always_ff @(posedge vga_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= ST_IDLE;
            r_paddle_y <= 10'(Y_CENTER);
            r_motion   <= '0;
            r_update   <= 1'b0;
            r_idle_cnt <= '0;
            r_pending  <= 1'b0;
        end else begin
            r_update <= frame_tick;
            if (frame_tick) begin
                r_state    <= w_next_state;
                r_paddle_y <= 10'(w_clamped);
                r_motion   <= 10'(w_applied);
                r_idle_cnt <= w_idle_next;
                r_pending  <= w_pend_next;
            end else begin
                r_pending  <= w_pend;
            end
        end
    end

    assign paddle_y      = r_paddle_y;
    assign paddle_motion = r_motion;
    assign paddle_size   = 10'(P_SIZE);
    assign mode          = r_state;
    assign update        = r_update;

endmodule
